hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage core; it drives enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards, taken-branch/jump redirects and data-memory wait states. It also freezes the pipe while memory is not ready and escalates to a halt on memory timeout.

## Interface
- MEM_TIMEOUT, 16: max consecutive frozen cycles before halt; legal 2..65535.
- REG_AW, 5: register address width.
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  the ID instruction reads rs1/rs2.
- ex_rd  in  REG_AW  destination register held in ID/EX.
- ex_mem_read  in  1  ID/EX holds a load.
- ex_redirect  in  1  branch taken or jump resolved in EX.
- mem_req  in  1  EX/MEM holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1  register load enables.
- if_id_flush, id_ex_flush  out  1  insert bubble (synchronous clear).
- mem_wb_bubble  out  1  MEM/WB loads a bubble.
- halt  out  1  sticky memory-timeout error.
- stall_cnt, flush_cnt  out  32  performance counters.

## Operation
- State register with states RUN, MEM_WAIT, HALT. Outputs are combinational from the state and inputs, in the priority order below.
- **Freeze** (`mem_req && !mem_ready`, in RUN or MEM_WAIT):
  - All enables = 0; flushes = 0; mem_wb_bubble = 1.
  - Next state MEM_WAIT; wait counter increments.
- **Redirect** (`ex_redirect`, not frozen):
  - if_id_flush = 1, id_ex_flush = 1; all enables = 1 (PC loads the target).
  - Overrides load-use.
- **Load-use** (not frozen, no redirect):
  - Condition: `ex_mem_read && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd))`.
  - Response: pc_en = 0, if_id_en = 0, id_ex_flush = 1; id_ex_en = 1, ex_mem_en = 1.
  - Lasts exactly one cycle because the load advances to MEM.
- **Default**: all enables = 1; flushes = 0; mem_wb_bubble = 0.
- MEM_WAIT:
  - Returns to RUN on the edge where mem_ready = 1; the wait counter clears.
  - If the counter reaches MEM_TIMEOUT with mem_ready still 0, go to HALT.
- HALT: all enables = 0, flushes = 0, mem_wb_bubble = 1, halt = 1. Only reset exits.
- A redirect or load-use arriving during a freeze is not latched. EX is frozen, so its inputs remain stable and the action is taken on the first unfrozen cycle.
- Register x0 never causes a hazard.

## Timing
- Reset (rst_n = 0, asynchronous):
  - State = RUN; wait counter = 0; halt = 0; counters = 0.
  - pc_en, if_id_en, id_ex_en, ex_mem_en = 0; if_id_flush, id_ex_flush = 1; mem_wb_bubble = 1.
- Reset release: normal decode from the first rising edge after rst_n rises. A reset in MEM_WAIT or HALT abandons the state immediately.
- Control outputs have zero-cycle latency, being combinational. State, timer and counters update on the rising clk edge.
- mem_ready = 1 on the same cycle as mem_req (single-cycle memory) causes no freeze.
- Wait counter width is ceil(log2(MEM_TIMEOUT+1)) and saturates; HALT is entered on the edge after MEM_TIMEOUT frozen cycles.
- Counters wrap modulo 2^32.
  - stall_cnt increments on each cycle where pc_en = 0 (load-use, freeze or halt).
  - flush_cnt increments on each redirect cycle.

## Configuration
- HAZARD_CTRL_PERF_EN:
  - Defined: stall_cnt and flush_cnt are implemented as described.
  - Undefined: the ports remain and are tied to 32'd0; no counter flops are generated.

## Structure
- Shared package hazard_pkg:
  - State enum (RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2) and STATE_W = 2.
  - REG_ZERO = 0 and the default MEM_TIMEOUT constant.
- One sub-module, hazard_perf_ctr: two 32-bit wrap counters with increment strobes. It is instantiated only under HAZARD_CTRL_PERF_EN.

## Test plan
- **Reset**: assert rst_n = 0 mid-MEM_WAIT (counter = 5) → enables 0, flushes 1, halt 0, state RUN; after release with idle inputs, all enables = 1.
- **Load-use**:
  - ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1 → one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1; stall_cnt +1.
  - Same with ex_rd = 0 → no stall.
- **Redirect vs load-use**: ex_redirect = 1 together with the load-use condition → if_id_flush = id_ex_flush = 1, pc_en = 1; flush_cnt +1, stall_cnt unchanged.
- **Memory wait**:
  - mem_req = 1, mem_ready = 0 for 3 cycles then 1 → 3 cycles with all enables 0 and mem_wb_bubble = 1, then RUN; stall_cnt +3.
  - A redirect held during the wait is applied on the first unfrozen cycle.
- **Timeout**: MEM_TIMEOUT = 4, mem_ready held 0 → halt = 1 after 4 frozen cycles and stays 1 when mem_ready later rises; only rst_n clears it.
- **Config**: build without HAZARD_CTRL_PERF_EN → stall_cnt = flush_cnt = 0 throughout the above scenarios.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned STATE_W         = 2;
    localparam int unsigned REG_ZERO        = 0;
    localparam int unsigned MEM_TIMEOUT_DEF = 16;
    localparam int unsigned PERF_W          = 32;

    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    // Pipeline control bundle driven to the stage registers
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } ctl_t;

    localparam ctl_t CTL_RUN      = ctl_t'(7'b1111_000);
    localparam ctl_t CTL_REDIRECT = ctl_t'(7'b1111_110);
    localparam ctl_t CTL_LOAD_USE = ctl_t'(7'b0011_010);
    localparam ctl_t CTL_FREEZE   = ctl_t'(7'b0000_001);
    localparam ctl_t CTL_RESET    = ctl_t'(7'b0000_111);

endpackage

// File: rtl/hazard_perf_ctr.sv
// Stall / flush performance counters, free-running and wrapping at 2^PERF_W.
module hazard_perf_ctr
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_stall_inc,
    input  logic              i_flush_inc,
    output logic [PERF_W-1:0] o_stall_cnt,
    output logic [PERF_W-1:0] o_flush_cnt
);

    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall_inc) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            if (i_flush_inc) r_flush_cnt <= r_flush_cnt + PERF_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencing: freeze on memory wait, redirect flush, load-use stall, timeout halt.
// Performance counters are built only when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              mem_wb_bubble,
    output logic              halt,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_freeze;
    logic             w_load_use;
    logic             w_timeout;
    logic             w_halt;
    ctl_t             w_ctl;

    // Load-use only matters when the load actually writes a real register
    assign w_load_use = ex_mem_read && (ex_rd != REG_AW'(REG_ZERO)) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    assign w_freeze  = mem_req && !mem_ready;
    assign w_cnt_inc = (r_wait_cnt == CNT_W'(MEM_TIMEOUT)) ? r_wait_cnt
                                                           : r_wait_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_inc == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next state and control outputs; priority freeze > redirect > load-use > run
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_ctl          = CTL_RUN;
        w_halt         = 1'b0;
        case (r_state)
            RUN, MEM_WAIT: begin
                if (w_freeze) begin
                    w_ctl          = CTL_FREEZE;
                    w_wait_cnt_nxt = w_cnt_inc;
                    w_state_nxt    = w_timeout ? HALT : MEM_WAIT;
                end else begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                    if (ex_redirect) begin
                        w_ctl = CTL_REDIRECT;
                    end else if (w_load_use) begin
                        w_ctl = CTL_LOAD_USE;
                    end
                end
            end
            HALT: begin
                w_ctl  = CTL_FREEZE;
                w_halt = 1'b1;
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
        // Hold the pipe cleared for as long as reset is asserted
        if (!rst_n) begin
            w_ctl  = CTL_RESET;
            w_halt = 1'b0;
        end
    end

    assign pc_en         = w_ctl.pc_en;
    assign if_id_en      = w_ctl.if_id_en;
    assign id_ex_en      = w_ctl.id_ex_en;
    assign ex_mem_en     = w_ctl.ex_mem_en;
    assign if_id_flush   = w_ctl.if_id_flush;
    assign id_ex_flush   = w_ctl.id_ex_flush;
    assign mem_wb_bubble = w_ctl.mem_wb_bubble;
    assign halt          = w_halt;

`ifdef HAZARD_CTRL_PERF_EN
    logic w_stall_inc;
    logic w_flush_inc;

    // A redirect is the only action that flushes while the PC still advances
    assign w_stall_inc = !w_ctl.pc_en;
    assign w_flush_inc = w_ctl.if_id_flush && w_ctl.pc_en;

    hazard_perf_ctr u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stall_inc (w_stall_inc),
        .i_flush_inc (w_flush_inc),
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
